command_tag_arbiter: RTL

//  Shares the PSL command interface and the 256-entry tag pool among NUM_CU compute-unit requesters.

---
 rtl/command_tag_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/command_tag_arbiter.sv
// Round-robin arbiter sharing PSL command credits and the tag pool among NUM_CU requesters.
// Grants are combinational in RUN; the issued command is registered one cycle later.
module command_tag_arbiter #(
  parameter int NUM_CU   = 4,
  parameter int CMD_W    = 64,
  parameter int CREDIT_W = 8
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled,
  input  logic [CREDIT_W-1:0]        croom,
  input  logic [NUM_CU-1:0]          req_valid,
  input  logic [NUM_CU*CMD_W-1:0]    req_cmd,
  output logic [NUM_CU-1:0]          req_ready,
  input  logic                       tag_buffer_ready,
  input  logic                       tag_valid,
  input  logic [7:0]                 command_tag,
  output logic                       tag_pop,
  input  logic                       credit_return,
  output logic                       cmd_out_valid,
  output logic [7:0]                 cmd_out_tag,
  output logic [$clog2(NUM_CU)-1:0]  cmd_out_src,
  output logic [CMD_W-1:0]           cmd_out_payload,
  output logic [CREDIT_W-1:0]        credits,
  output logic                       credit_error
);

  localparam int SRC_W = $clog2(NUM_CU);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand_idx;
  logic             found;
  logic             issue;
  logic [CMD_W-1:0] cmd_arr [NUM_CU];

  for (genvar g = 0; g < NUM_CU; g++) begin : g_split
    assign cmd_arr[g] = req_cmd[g*CMD_W +: CMD_W];
  end

  // Scan from the round-robin pointer, wrapping, and take the first requester.
  always_comb begin
    grant_idx = '0;
    cand_idx  = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_CU; k++) begin
      cand_idx = SRC_W'((int'(rr_ptr) + k) % NUM_CU);
      if (!found && req_valid[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign issue     = (state == RUN) && found && (credits != '0) && tag_buffer_ready && tag_valid;
  assign req_ready = issue ? (NUM_CU'(1) << grant_idx) : '0;
  assign tag_pop   = issue;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      credits         <= '0;
      credit_error    <= 1'b0;
      cmd_out_valid   <= 1'b0;
      cmd_out_tag     <= '0;
      cmd_out_src     <= '0;
      cmd_out_payload <= '0;
    end else begin
      cmd_out_valid <= issue;
      if (issue) begin
        cmd_out_tag     <= command_tag;
        cmd_out_src     <= grant_idx;
        cmd_out_payload <= cmd_arr[grant_idx];
        rr_ptr          <= (grant_idx == SRC_W'(NUM_CU - 1)) ? '0 : grant_idx + 1'b1;
      end

      // A return outside RUN, or one that would overflow the counter, is a protocol error.
      if (credit_return && ((state != RUN) || (!issue && credits == '1)))
        credit_error <= 1'b1;

      if (!enabled) begin
        state   <= IDLE;
        credits <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= LOAD;
            credits <= '0;
          end
          LOAD: begin
            state   <= RUN;
            credits <= croom;
          end
          RUN: begin
            if (issue && !credit_return)
              credits <= credits - 1'b1;
            else if (credit_return && !issue && credits != '1)
              credits <= credits + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
